uart_cmd_seq: RTL and testbench

UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

---
 rtl/uart_cmd_seq.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles two bytes from UART_rx into a 16-bit command
// {high byte, low byte} and presents it until the consumer acknowledges.
// Optional feature macro: CMD_TIMEOUT_EN -- when defined, a partial command
// (high byte received, low byte missing) is discarded after TIMEOUT_CYC
// cycles and a one-cycle timeout pulse is issued. When undefined, the timer
// is not built, timeout is tied low and the block waits indefinitely.
module uart_cmd_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        timeout,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic load_hi;
    logic load_lo;
    logic clr_cmd;
    logic set_ovr;
    logic clr_ovr;
    logic term_cnt;

    // Every received byte is consumed in the same cycle it is offered;
    // the strobe is forced low while reset is held.
    assign clr_rdy = rdy & rst_n;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the datapath enables for each transition.
    always_comb begin
        state_next = state;
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        clr_cmd    = 1'b0;
        set_ovr    = 1'b0;
        clr_ovr    = 1'b0;
        case (state)
            IDLE: begin
                if (rdy) begin
                    load_hi    = 1'b1;
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (rdy) begin
                    load_lo    = 1'b1;
                    state_next = HOLD;
                end else if (term_cnt) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (clr_cmd_rdy) begin
                    clr_cmd = 1'b1;
                    if (rdy) begin
                        load_hi    = 1'b1;
                        state_next = WAIT_LO;
                    end else begin
                        clr_ovr    = 1'b1;
                        state_next = IDLE;
                    end
                end else if (rdy) begin
                    set_ovr = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command register, ready flag and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= 16'h0000;
            cmd_rdy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load_hi) begin
                cmd[15:8] <= rx_data;
            end
            if (load_lo) begin
                cmd[7:0] <= rx_data;
            end
            if (load_lo) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd) begin
                cmd_rdy <= 1'b0;
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    logic [15:0] timer;
    logic        timeout_q;

    assign term_cnt = (timer == (TIMEOUT_CYC - 16'd1));
    assign timeout  = timeout_q;

    // Inter-byte timer: runs only while waiting for the low byte and is
    // zero on every entry to WAIT_LO; the byte wins on the terminal cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if ((state == WAIT_LO) && (state_next == WAIT_LO)) begin
                timer <= timer + 16'd1;
            end else begin
                timer <= 16'd0;
            end
            timeout_q <= (state == WAIT_LO) && !rdy && term_cnt;
        end
    end
`else
    // No timer: the low byte is awaited forever. The parameter is still
    // referenced so both builds share an identical interface.
    assign term_cnt = 1'b0;
    assign timeout  = (TIMEOUT_CYC == 16'd0) & 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Testbench for uart_cmd_seq: directed byte sequences checked every cycle
// against a behavioural command-assembly model, plus literal expectations.
// The timeout scenarios are exercised when CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_seq;

    localparam logic [15:0] TCYC = 16'd100;
`ifdef CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        timeout;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;
    bit check_en = 1'b0;

    // behavioural model state
    logic [15:0] m_cmd = 16'h0000;
    bit          m_cmd_rdy = 1'b0;
    bit          m_ovr = 1'b0;
    bit          m_to = 1'b0;
    bit          m_have_hi = 1'b0;
    int          m_wait = 0;

    uart_cmd_seq #(.TIMEOUT_CYC(TCYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rx_data     (rx_data),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Model: a command is "presented" while m_cmd_rdy; a high byte is
    // "pending" while m_have_hi; m_wait counts idle cycles spent pending.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd = 16'h0000; m_cmd_rdy = 1'b0; m_ovr = 1'b0;
            m_to = 1'b0; m_have_hi = 1'b0; m_wait = 0;
        end else begin
            m_to = 1'b0;
            if (m_cmd_rdy) begin
                if (clr_cmd_rdy) begin
                    m_cmd_rdy = 1'b0;
                    if (rdy) begin
                        m_cmd[15:8] = rx_data; m_have_hi = 1'b1; m_wait = 0;
                    end else begin
                        m_ovr = 1'b0;
                    end
                end else if (rdy) begin
                    m_ovr = 1'b1;
                end
            end else if (m_have_hi) begin
                if (rdy) begin
                    m_cmd[7:0] = rx_data; m_cmd_rdy = 1'b1; m_have_hi = 1'b0;
                end else begin
                    m_wait = m_wait + 1;
                    if (TO_EN && m_wait == int'(TCYC)) begin
                        m_to = 1'b1; m_have_hi = 1'b0;
                    end
                end
            end else if (rdy) begin
                m_cmd[15:8] = rx_data; m_have_hi = 1'b1; m_wait = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (clr_rdy === 1'b1) pulse_cnt++;
        if (check_en) begin
            vectors++;
            if ({cmd, cmd_rdy, timeout, overrun, clr_rdy} !==
                {m_cmd, m_cmd_rdy, m_to, m_ovr, (rdy & rst_n)}) begin
                miscompares++;
                $display("[TB] FAIL cycle_cmp t=%0t got cmd=%h rdy=%b to=%b ovr=%b clr=%b want cmd=%h rdy=%b to=%b ovr=%b clr=%b",
                         $time, cmd, cmd_rdy, timeout, overrun, clr_rdy,
                         m_cmd, m_cmd_rdy, m_to, m_ovr, rdy & rst_n);
            end
        end
    end

    task automatic check_output(input string name, input logic [15:0] got,
                                input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Hold the inputs for one clock cycle, then return them to idle.
    task automatic apply_stimulus(input logic r, input logic [7:0] d,
                                  input logic a);
        rdy = r; rx_data = d; clr_cmd_rdy = a;
        @(posedge clk); #1;
        rdy = 1'b0; clr_cmd_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_en = 1'b1;
        check_output("reset_cmd", cmd, 16'h0000);
        check_output("reset_flags", {12'd0, cmd_rdy, timeout, overrun, clr_rdy}, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // normal command A5 3C
        pulse_cnt = 0;
        apply_stimulus(1'b1, 8'hA5, 1'b0);
        check_output("hi_no_rdy", {15'd0, cmd_rdy}, 16'h0000);
        apply_stimulus(1'b1, 8'h3C, 1'b0);
        check_output("norm_cmd", cmd, 16'hA53C);
        check_output("norm_rdy", {15'd0, cmd_rdy}, 16'h0001);
        idle(3);
        check_output("clr_rdy_pulses", pulse_cnt[15:0], 16'd2);
        check_output("hold_stable", cmd, 16'hA53C);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("ack_rdy", {15'd0, cmd_rdy}, 16'h0000);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        idle(1);

        // overrun: 1234 presented, FF dropped, then ack
        apply_stimulus(1'b1, 8'h12, 1'b0);
        apply_stimulus(1'b1, 8'h34, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 1'b0);
        check_output("ovr_cmd", cmd, 16'h1234);
        check_output("ovr_flag", {15'd0, overrun}, 16'h0001);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("ovr_ack", {14'd0, cmd_rdy, overrun}, 16'h0000);

        // simultaneous ack+byte keeps a sticky overrun
        apply_stimulus(1'b1, 8'h9A, 1'b0);
        apply_stimulus(1'b1, 8'hBC, 1'b0);
        apply_stimulus(1'b1, 8'hEE, 1'b0);
        apply_stimulus(1'b1, 8'h77, 1'b1);
        check_output("sim_ovr_kept", {14'd0, cmd_rdy, overrun}, 16'h0001);
        apply_stimulus(1'b1, 8'h01, 1'b0);
        check_output("sim_ovr_cmd", cmd, 16'h7701);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("sim_ovr_clr", {15'd0, overrun}, 16'h0000);

        // simultaneous ack+byte with no overrun
        apply_stimulus(1'b1, 8'h9A, 1'b0);
        apply_stimulus(1'b1, 8'hBC, 1'b0);
        apply_stimulus(1'b1, 8'h77, 1'b1);
        apply_stimulus(1'b1, 8'h01, 1'b0);
        check_output("sim_cmd", cmd, 16'h7701);
        check_output("sim_flags", {14'd0, cmd_rdy, overrun}, 16'h0002);
        apply_stimulus(1'b0, 8'h00, 1'b1);

`ifdef CMD_TIMEOUT_EN
        // timeout exactly 100 cycles after entering WAIT_LO
        apply_stimulus(1'b1, 8'h55, 1'b0);
        idle(99);
        check_output("to_early", {15'd0, timeout}, 16'h0000);
        idle(1);
        check_output("to_pulse", {15'd0, timeout}, 16'h0001);
        idle(1);
        check_output("to_one_cycle", {15'd0, timeout}, 16'h0000);
        apply_stimulus(1'b1, 8'h12, 1'b0);
        apply_stimulus(1'b1, 8'h34, 1'b0);
        check_output("to_next_cmd", cmd, 16'h1234);
        apply_stimulus(1'b0, 8'h00, 1'b1);

        // byte on the terminal-count cycle wins
        apply_stimulus(1'b1, 8'h66, 1'b0);
        idle(99);
        apply_stimulus(1'b1, 8'h99, 1'b0);
        check_output("race_flags", {14'd0, cmd_rdy, timeout}, 16'h0002);
        check_output("race_cmd", cmd, 16'h6699);
        idle(1);
        check_output("race_no_to", {15'd0, timeout}, 16'h0000);
        apply_stimulus(1'b0, 8'h00, 1'b1);
`else
        // without the timer the low byte is awaited indefinitely
        apply_stimulus(1'b1, 8'h55, 1'b0);
        idle(150);
        check_output("nto_no_pulse", {15'd0, timeout}, 16'h0000);
        apply_stimulus(1'b1, 8'h34, 1'b0);
        check_output("nto_cmd", cmd, 16'h5534);
        apply_stimulus(1'b0, 8'h00, 1'b1);
`endif

        // reset mid-command
        apply_stimulus(1'b1, 8'hAA, 1'b0);
        rdy = 1'b1; rx_data = 8'hDD;
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_cmd", cmd, 16'h0000);
        check_output("rst_flags", {12'd0, cmd_rdy, timeout, overrun, clr_rdy}, 16'h0000);
        @(posedge clk); #1;
        rdy = 1'b0; rst_n = 1'b1;
        idle(1);
        apply_stimulus(1'b1, 8'hBB, 1'b0);
        apply_stimulus(1'b1, 8'hCC, 1'b0);
        check_output("rst_next_cmd", cmd, 16'hBBCC);
        check_output("rst_next_rdy", {15'd0, cmd_rdy}, 16'h0001);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        idle(2);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
